imem_loader: RTL

//   Write side of the 512x8 byte-addressed instruction memory: program loader.

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_byte_serializer.sv | 20 ++
 rtl/imem_loader.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
// State encoding, memory geometry and default port widths.
package imem_loader_pkg;

  localparam int IMEM_ADDR_W    = 9;
  localparam int IMEM_CNT_W     = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int IMEM_BYTES     = 512;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_WORD = 3'd1,
    ST_WRITE     = 3'd2,
    ST_DONE      = 3'd3,
    ST_ERROR     = 3'd4
  } state_e;

endpackage

// File: rtl/imem_byte_serializer.sv
// Picks one byte of a 32-bit instruction word, MSB first:
// idx 0 -> word[31:24] ... idx 3 -> word[7:0].
module imem_byte_serializer (
  input  logic [31:0] word_i,
  input  logic [1:0]  idx_i,
  output logic [7:0]  byte_o
);

  always_comb begin
    byte_o = word_i[31:24];
    case (idx_i)
      2'd0:    byte_o = word_i[31:24];
      2'd1:    byte_o = word_i[23:16];
      2'd2:    byte_o = word_i[15:8];
      2'd3:    byte_o = word_i[7:0];
      default: byte_o = word_i[31:24];
    endcase
  end

endmodule

// File: rtl/imem_loader.sv
// Program loader for the byte-addressed instruction memory: accepts 32-bit words
// over valid/ready and writes each as four bytes, big-endian, holding the CPU meanwhile.
//
//   state      | meaning
//   IDLE       | waiting for start
//   WAIT_WORD  | in_ready high, waiting for the next word
//   WRITE      | writing byte idx (0..3) of the latched word
//   DONE       | one-cycle done pulse
//   ERROR      | misaligned base or address wrap; err set
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int CNT_W  = IMEM_CNT_W
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [CNT_W-1:0]  word_count_i,
  input  logic              in_valid_i,
  input  logic [31:0]       in_word_i,
  output logic              in_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  output logic              busy_o,
  output logic              cpu_hold_o,
  output logic              done_o,
  output logic              err_o
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        idx_q, idx_d;
  logic              err_q, err_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic [7:0]        ser_byte;
  logic              at_top;

  // Last word slot of memory: advancing past it would wrap to address 0.
  assign at_top = &ptr_q[ADDR_W-1:2];

  imem_byte_serializer u_ser (
    .word_i (word_d),
    .idx_i  (idx_d),
    .byte_o (ser_byte)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    word_d      = word_q;
    idx_d       = idx_q;
    err_d       = err_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          ptr_d       = base_addr_i;
          remaining_d = word_count_i;
          err_d       = 1'b0;
          if (base_addr_i[1:0] != 2'b00) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end else if (word_count_i == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT_WORD;
          end
        end
      end
      ST_WAIT_WORD: begin
        if (in_valid_i) begin
          word_d  = in_word_i;
          idx_d   = 2'd0;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (idx_q == 2'd3) begin
          ptr_d       = ptr_q + ADDR_W'(BYTES_PER_WORD);
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end else if (at_top) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end else begin
            state_d = ST_WAIT_WORD;
          end
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Write port is registered from next-state values so the byte for idx k
  // is on the bus during the cycle the FSM sits in WRITE with idx k.
  always_comb begin
    mem_we_d    = (state_d == ST_WRITE);
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (mem_we_d) begin
      mem_addr_d  = {ptr_d[ADDR_W-1:2], idx_d};
      mem_wdata_d = ser_byte;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      word_q      <= '0;
      idx_q       <= 2'd0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign in_ready_o  = (state_q == ST_WAIT_WORD);
  assign busy_o      = (state_q == ST_WAIT_WORD) || (state_q == ST_WRITE);
  assign cpu_hold_o  = busy_o;
  assign done_o      = (state_q == ST_DONE);
  assign err_o       = err_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule
